// File: rtl/pipeline_pkg.sv
// Shared IF/ID pipeline definitions: default widths, the NOP bubble word, FSM state encoding and beat layout.
package pipeline_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = ST_EMPTY,
    ONE   = ST_ONE,
    TWO   = ST_TWO
  } ifid_state_t;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } ifid_beat_t;

  function automatic logic [PC_W_DEF-1:0] pc_plus4(input logic [PC_W_DEF-1:0] pc);
    return pc + PC_W_DEF'(4);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_clr_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_full;

  assign w_full = &r_count;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_count <= '0;
    end else if (i_en && !w_full) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/if_id_skid_buffer.sv
// IF/ID pipeline register as a 2-entry skid buffer with flush and NOP bubbles.
// Define IFID_PERF_EN to add the saturating stall/flush performance counters.
module if_id_skid_buffer
  import pipeline_pkg::*;
#(
  parameter int                 PC_W     = PC_W_DEF,
  parameter int                 INSTR_W  = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_WORD_DEF)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [PC_W-1:0]    i_in_pc,
  input  logic [INSTR_W-1:0] i_in_instr,
  input  logic               i_flush,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [PC_W-1:0]    o_out_pc,
  output logic [PC_W-1:0]    o_out_pc4,
  output logic [INSTR_W-1:0] o_out_instr
`ifdef IFID_PERF_EN
  ,
  output logic [31:0]        o_stall_cnt,
  output logic [15:0]        o_flush_cnt
`endif
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } beat_t;

  ifid_state_t r_state;
  ifid_state_t w_state_next;
  beat_t       r_main;
  beat_t       w_main_next;
  beat_t       r_skid;
  beat_t       w_skid_next;
  beat_t       w_in_beat;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        w_in_fire;
  logic        w_out_fire;

  assign w_in_beat  = '{pc: i_in_pc, instr: i_in_instr};
  assign w_in_fire  = i_in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & i_out_ready;

  // main is the slot presented to decode, skid catches the beat accepted while main is stalled
  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_main_next  = w_in_beat;
          w_state_next = ONE;
        end
      end
      ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_next = w_in_beat;
        end else if (w_in_fire) begin
          w_skid_next  = w_in_beat;
          w_state_next = TWO;
        end else if (w_out_fire) begin
          w_state_next = EMPTY;
        end
      end
      TWO: begin
        if (w_out_fire) begin
          w_main_next  = r_skid;
          w_state_next = ONE;
        end
      end
      default: begin
        w_state_next = EMPTY;
      end
    endcase
    // Redirect discards everything, including a beat accepted on the same edge
    if (i_flush) begin
      w_state_next = EMPTY;
    end
  end

  // Handshake flags are registered from the next state so in_ready never sees out_ready combinationally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_main      <= w_main_next;
      r_skid      <= w_skid_next;
      r_in_ready  <= (w_state_next != TWO);
      r_out_valid <= (w_state_next != EMPTY);
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_pc    = r_main.pc;
  assign o_out_pc4   = r_main.pc + PC_W'(4);
  assign o_out_instr = r_out_valid ? r_main.instr : NOP_WORD;

`ifdef IFID_PERF_EN
  sat_counter #(.W(32)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_clr_n (i_rst_n),
    .i_en    (i_in_valid & ~r_in_ready),
    .o_count (o_stall_cnt)
  );

  sat_counter #(.W(16)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_clr_n (i_rst_n),
    .i_en    (i_flush),
    .o_count (o_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Scoreboard bench for if_id_skid_buffer: accepted beats are queued, a negedge monitor checks each consumed beat.
module tb_if_id_skid_buffer;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        o_in_ready;
  logic        o_out_valid;
  logic [31:0] o_out_pc;
  logic [31:0] o_out_pc4;
  logic [31:0] o_out_instr;
`ifdef IFID_PERF_EN
  logic [31:0] o_stall_cnt;
  logic [15:0] o_flush_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;

  ifid_beat_t exp_q[$];
  ifid_beat_t mon_beat;
  logic        hold_v = 1'b0;
  logic [31:0] hold_pc = '0;
  logic [31:0] hold_instr = '0;

  logic [31:0] t2_pc[4]  = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] t2_pc4[4] = '{32'h4, 32'h8, 32'hC, 32'h10};

  if_id_skid_buffer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_pc     (in_pc),
    .i_in_instr  (in_instr),
    .i_flush     (flush),
    .o_out_valid (o_out_valid),
    .i_out_ready (out_ready),
    .o_out_pc    (o_out_pc),
    .o_out_pc4   (o_out_pc4),
    .o_out_instr (o_out_instr)
`ifdef IFID_PERF_EN
    ,
    .o_stall_cnt (o_stall_cnt),
    .o_flush_cnt (o_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic fl, input logic ordy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // Expected-beat tracker: record what the handshake accepts, drop on flush/reset
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else if (in_valid && o_in_ready) begin
      exp_q.push_back('{pc: in_pc, instr: in_instr});
    end
  end

  // Monitor: consume on out_valid & out_ready, check bubbles and hold stability
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (o_out_valid) begin
        if (hold_v) begin
          chk32("hold_pc", o_out_pc, hold_pc);
          chk32("hold_instr", o_out_instr, hold_instr);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got pc %h required no beat", o_out_pc);
          end else begin
            mon_beat = exp_q.pop_front();
            chk32("beat_pc", o_out_pc, mon_beat.pc);
            chk32("beat_pc4", o_out_pc4, mon_beat.pc + 32'd4);
            chk32("beat_instr", o_out_instr, mon_beat.instr);
            $display("beat pc=%h pc4=%h instr=%h", o_out_pc, o_out_pc4, o_out_instr);
          end
        end
      end else begin
        chk32("bubble_instr", o_out_instr, 32'h0000_0000);
      end
      hold_v     = o_out_valid && !out_ready;
      hold_pc    = o_out_pc;
      hold_instr = o_out_instr;
    end
  end

  initial begin
    // 1: reset held with a beat on offer
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_pc    = 32'h40;
    in_instr = 32'h1234_5678;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk1("rst_out_valid", o_out_valid, 1'b0);
      chk32("rst_out_instr", o_out_instr, 32'h0);
      chk1("rst_in_ready", o_in_ready, 1'b1);
    end
    chk32("rst_out_pc", o_out_pc, 32'h0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk1("post_rst_empty", o_out_valid, 1'b0);

    // 2: full-rate stream
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, t2_pc[i], 32'h2008_0000 + 32'(i), 1'b0, 1'b1);
      chk1("stream_valid", o_out_valid, 1'b1);
      chk32("stream_pc", o_out_pc, t2_pc[i]);
      chk32("stream_pc4", o_out_pc4, t2_pc4[i]);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk1("stream_drained", o_out_valid, 1'b0);

    // 3: backpressure fills the skid slot
    drive(1'b1, 32'h10, 32'hA0, 1'b0, 1'b0);
    chk1("bp_ready1", o_in_ready, 1'b1);
    chk32("bp_pc1", o_out_pc, 32'h10);
    drive(1'b1, 32'h14, 32'hA1, 1'b0, 1'b0);
    chk1("bp_ready2", o_in_ready, 1'b0);
    chk32("bp_pc2", o_out_pc, 32'h10);
    drive(1'b1, 32'h18, 32'hA2, 1'b0, 1'b0);
    chk1("bp_ready3", o_in_ready, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk32("bp_skid_pc", o_out_pc, 32'h14);
    chk1("bp_ready4", o_in_ready, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk1("bp_drained", o_out_valid, 1'b0);

    // 4: flush in TWO with a beat on offer
    drive(1'b1, 32'h20, 32'hB0, 1'b0, 1'b0);
    drive(1'b1, 32'h24, 32'hB4, 1'b0, 1'b0);
    chk1("fl_full", o_in_ready, 1'b0);
    drive(1'b1, 32'h18, 32'hB8, 1'b1, 1'b0);
    chk1("fl_valid", o_out_valid, 1'b0);
    chk1("fl_ready", o_in_ready, 1'b1);
    chk32("fl_nop", o_out_instr, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk1("fl_still_empty", o_out_valid, 1'b0);
    chk32("fl_queue", 32'(exp_q.size()), 32'h0);
    // flush coinciding with consumption
    drive(1'b1, 32'h28, 32'hC0, 1'b0, 1'b1);
    chk32("flc_pc", o_out_pc, 32'h28);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk1("flc_valid", o_out_valid, 1'b0);

    // 5: pc+4 wrap
    drive(1'b1, 32'hFFFF_FFFC, 32'h8C08_0000, 1'b0, 1'b1);
    chk32("wrap_pc", o_out_pc, 32'hFFFF_FFFC);
    chk32("wrap_pc4", o_out_pc4, 32'h0000_0000);
    chk32("wrap_instr", o_out_instr, 32'h8C08_0000);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // reset mid-stream drops held beats
    drive(1'b1, 32'h30, 32'hD0, 1'b0, 1'b0);
    drive(1'b1, 32'h34, 32'hD4, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("mrst_valid", o_out_valid, 1'b0);
    chk1("mrst_ready", o_in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk1("mrst_empty", o_out_valid, 1'b0);

`ifdef IFID_PERF_EN
    // 6: performance counters
    chk32("perf_stall0", o_stall_cnt, 32'h0);
    chk32("perf_flush0", 32'(o_flush_cnt), 32'h0);
    drive(1'b1, 32'h40, 32'hE0, 1'b0, 1'b0);
    drive(1'b1, 32'h44, 32'hE4, 1'b0, 1'b0);
    repeat (5) drive(1'b1, 32'h48, 32'hE8, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk32("perf_stall5", o_stall_cnt, 32'd5);
    chk32("perf_flush2", 32'(o_flush_cnt), 32'd2);
    repeat (65540) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk32("perf_flush_sat", 32'(o_flush_cnt), 32'h0000_FFFF);
    chk32("perf_stall_hold", o_stall_cnt, 32'd5);
`endif

    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk32("final_queue", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
